// File: rtl/mbist_controller.sv
// mbist_controller: March C- memory BIST sequencer.
//   Runs March C- over the whole memory for three data backgrounds
//   (solid, checkerboard, row stripe). Each background's pattern comes from
//   an external decoder with a two-cycle latency. The first read miscompare
//   is logged and the test stops there.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 level sampled in IDLE/DONE; starts a test
//   dec_in / dec_out      background code to the decoder / pattern back
//   mem_addr, mem_we, mem_re, mem_wdata, mem_rdata
//                         memory port; read data arrives the cycle after mem_re
//   busy, done, fail      status
//   fail_addr, fail_bg, fail_elem
//                         first-failure log
module mbist_controller #(
    parameter int AW = 8,
    parameter int WL = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [3:0]    dec_in,
    input  logic [WL-1:0] dec_out,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic          mem_re,
    output logic [WL-1:0] mem_wdata,
    input  logic [WL-1:0] mem_rdata,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [AW-1:0] fail_addr,
    output logic [1:0]    fail_bg,
    output logic [2:0]    fail_elem
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_RUN, S_DRAIN, S_DONE
    } state_t;

    localparam logic [AW-1:0] ADDR_MAX = '1;
    localparam logic [2:0] M0 = 3'd0, M1 = 3'd1, M2 = 3'd2,
                           M3 = 3'd3, M4 = 3'd4, M5 = 3'd5;

    state_t        state_q, state_d;
    logic [1:0]    bg_q, bg_d;
    logic [2:0]    elem_q, elem_d;
    logic          op_q, op_d;          // 0: first op of the element, 1: second
    logic [AW-1:0] addr_q, addr_d;
    logic          settle_q, settle_d;
    logic          cmp_vld_q, cmp_vld_d;
    logic [WL-1:0] cmp_exp_q, cmp_exp_d;
    logic [AW-1:0] cmp_addr_q, cmp_addr_d;
    logic [1:0]    cmp_bg_q, cmp_bg_d;
    logic [2:0]    cmp_elem_q, cmp_elem_d;
    logic          fail_q, fail_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic [1:0]    fail_bg_q, fail_bg_d;
    logic [2:0]    fail_elem_q, fail_elem_d;

    // Current-operation decode. Every element except M0 opens with a read.
    logic          is_down, is_read, last_op, op_inv, term_addr, running, mismatch;
    logic [WL-1:0] op_data;
    logic [2:0]    elem_nx;

    assign is_down   = (elem_q == M3) || (elem_q == M4);
    assign is_read   = (elem_q != M0) && !op_q;
    assign last_op   = (elem_q == M0) || (elem_q == M5) || op_q;
    // Reads of M2/M4 and writes of M1/M3 use the complement ~D.
    assign op_inv    = is_read ? ((elem_q == M2) || (elem_q == M4))
                               : ((elem_q == M1) || (elem_q == M3));
    assign op_data   = op_inv ? ~dec_out : dec_out;
    assign term_addr = is_down ? (addr_q == '0) : (addr_q == ADDR_MAX);
    assign elem_nx   = elem_q + 3'd1;
    assign running   = (state_q == S_RUN);
    assign mismatch  = cmp_vld_q && (mem_rdata != cmp_exp_q);

    assign dec_in    = {1'b0, bg_q, 1'b1};
    assign mem_addr  = addr_q;
    assign mem_we    = running && !is_read;
    assign mem_re    = running && is_read;
    assign mem_wdata = (running && !is_read) ? op_data : '0;
    assign busy      = (state_q == S_SETTLE) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_bg   = fail_bg_q;
    assign fail_elem = fail_elem_q;

    always_comb begin
        state_d     = state_q;
        bg_d        = bg_q;
        elem_d      = elem_q;
        op_d        = op_q;
        addr_d      = addr_q;
        settle_d    = settle_q;
        cmp_vld_d   = 1'b0;           // a registered read is consumed the next cycle
        cmp_exp_d   = cmp_exp_q;
        cmp_addr_d  = cmp_addr_q;
        cmp_bg_d    = cmp_bg_q;
        cmp_elem_d  = cmp_elem_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_bg_d   = fail_bg_q;
        fail_elem_d = fail_elem_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_SETTLE;
                    bg_d        = 2'd0;
                    settle_d    = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_bg_d   = '0;
                    fail_elem_d = '0;
                end
            end
            // Two quiet cycles cover the decoder latency after dec_in changes.
            S_SETTLE: begin
                if (settle_q) begin
                    state_d = S_RUN;
                    elem_d  = M0;
                    op_d    = 1'b0;
                    addr_d  = '0;
                end else begin
                    settle_d = 1'b1;
                end
            end
            S_RUN: begin
                if (is_read) begin
                    cmp_vld_d  = 1'b1;
                    cmp_exp_d  = op_data;
                    cmp_addr_d = addr_q;
                    cmp_bg_d   = bg_q;
                    cmp_elem_d = elem_q;
                end
                if (!last_op) begin
                    op_d = 1'b1;
                end else begin
                    op_d = 1'b0;
                    if (!term_addr) begin
                        addr_d = is_down ? addr_q - AW'(1) : addr_q + AW'(1);
                    end else if (elem_q != M5) begin
                        elem_d = elem_nx;
                        // M3 and M4 walk downwards, so they start at the top.
                        addr_d = ((elem_nx == M3) || (elem_nx == M4)) ? ADDR_MAX : '0;
                    end else if (bg_q != 2'd2) begin
                        bg_d     = bg_q + 2'd1;
                        state_d  = S_SETTLE;
                        settle_d = 1'b0;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // The final read of a background can miscompare during SETTLE or DRAIN.
        if (mismatch && busy) begin
            state_d     = S_DONE;
            cmp_vld_d   = 1'b0;
            fail_d      = 1'b1;
            fail_addr_d = cmp_addr_q;
            fail_bg_d   = cmp_bg_q;
            fail_elem_d = cmp_elem_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bg_q        <= '0;
            elem_q      <= '0;
            op_q        <= 1'b0;
            addr_q      <= '0;
            settle_q    <= 1'b0;
            cmp_vld_q   <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
            cmp_bg_q    <= '0;
            cmp_elem_q  <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_bg_q   <= '0;
            fail_elem_q <= '0;
        end else begin
            state_q     <= state_d;
            bg_q        <= bg_d;
            elem_q      <= elem_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            settle_q    <= settle_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_exp_q   <= cmp_exp_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_bg_q    <= cmp_bg_d;
            cmp_elem_q  <= cmp_elem_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_bg_q   <= fail_bg_d;
            fail_elem_q <= fail_elem_d;
        end
    end

endmodule

// File: tb/tb_mbist_controller.sv
// tb_mbist_controller: bench for mbist_controller with a 256x4 memory model,
// a two-stage pattern decoder, optional single stuck-at bit faults and a
// loop-based March C- reference producing the expected cycle-by-cycle trace.
module tb_mbist_controller;
    localparam int AW = 8;
    localparam int WL = 4;
    localparam int N  = 1 << AW;
    localparam int FULL_BUSY = 3 * (2 + 10 * N) + 1;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [3:0]    dec_in;
    logic [WL-1:0] dec_out;
    logic [AW-1:0] mem_addr;
    logic          mem_we, mem_re;
    logic [WL-1:0] mem_wdata, mem_rdata;
    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [1:0]    fail_bg;
    logic [2:0]    fail_elem;

    mbist_controller #(.AW(AW), .WL(WL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dec_in(dec_in), .dec_out(dec_out),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .fail(fail),
        .fail_addr(fail_addr), .fail_bg(fail_bg), .fail_elem(fail_elem)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Pattern decoder: solid, checkerboard, row stripe; bit0 = 1 means no negation.
    function automatic logic [3:0] pat(input logic [1:0] b);
        case (b)
            2'd0:    return 4'b0000;
            2'd1:    return 4'b0101;
            2'd2:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    logic [3:0] dec_p1, dec_p2;
    always @(posedge clk) begin
        dec_p1 <= dec_in[0] ? pat(dec_in[2:1]) : ~pat(dec_in[2:1]);
        dec_p2 <= dec_p1;
    end
    assign dec_out = dec_p2;

    // Fault injection: one bit of one word stuck at f_val.
    bit f_en = 1'b0, f_val = 1'b0;
    int f_addr = 0, f_bit = 0;

    function automatic logic [3:0] flt(input int a, input logic [3:0] w);
        logic [3:0] r;
        r = w;
        if (f_en && a == f_addr) r[f_bit] = f_val;
        return r;
    endfunction

    logic [3:0] tmem [N];
    logic [3:0] rdata_r;
    always @(posedge clk) begin
        if (mem_we) tmem[mem_addr] <= flt(int'(mem_addr), mem_wdata);
        if (mem_re) rdata_r <= flt(int'(mem_addr), tmem[mem_addr]);
    end
    assign mem_rdata = rdata_r;

    // Reference: one entry per busy cycle.
    typedef struct {
        logic          we;
        logic          re;
        logic [AW-1:0] addr;
        logic [WL-1:0] wd;
        logic [1:0]    bg;
        logic [2:0]    elem;
    } op_t;

    op_t expq[$];
    int  fail_idx;
    int  ef_addr, ef_bg, ef_elem;

    function automatic op_t mk(input bit we, input bit re, input int a,
                               input logic [3:0] wd, input int b, input int e);
        op_t o;
        o.we = we; o.re = re; o.addr = AW'(a); o.wd = wd; o.bg = 2'(b); o.elem = 3'(e);
        return o;
    endfunction

    task automatic build_ref();
        logic [3:0] m [N];
        logic [3:0] d, v;
        int a;
        expq.delete();
        fail_idx = -1; ef_addr = 0; ef_bg = 0; ef_elem = 0;
        for (int b = 0; b < 3; b++) begin
            d = pat(2'(b));
            repeat (2) expq.push_back(mk(0, 0, 0, 4'h0, b, 0));
            for (int e = 0; e < 6; e++) begin
                for (int k = 0; k < N; k++) begin
                    a = (e == 3 || e == 4) ? N - 1 - k : k;
                    if (e != 0) begin
                        v = (e == 2 || e == 4) ? ~d : d;
                        expq.push_back(mk(0, 1, a, 4'h0, b, e));
                        if (m[a] !== v && fail_idx < 0) begin
                            fail_idx = expq.size() - 1;
                            ef_addr = a; ef_bg = b; ef_elem = e;
                        end
                    end
                    if (e != 5) begin
                        v = (e == 1 || e == 3) ? ~d : d;
                        m[a] = flt(a, v);
                        expq.push_back(mk(1, 0, a, v, b, e));
                    end
                end
            end
        end
        expq.push_back(mk(0, 0, 0, 4'h0, 2, 0));   // final compare cycle
        // After a miscompare the run stops one cycle after the failing read.
        if (fail_idx >= 0)
            while (expq.size() > fail_idx + 2) void'(expq.pop_back());
    endtask

    int         last_cnt;
    logic [3:0] obs_b1m1, obs_b2m0;

    task automatic run_test(input bit hold);
        int  cnt, terr, acc;
        bit  g1, g2;
        op_t e;
        build_ref();
        cnt = 0; terr = 0; g1 = 0; g2 = 0;
        obs_b1m1 = 'x; obs_b2m0 = 'x;
        @(negedge clk);
        start = 1'b1;
        forever begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (!busy) break;
            if (cnt < expq.size()) begin
                e = expq[cnt];
                if (mem_we !== e.we || mem_re !== e.re || dec_in !== {1'b0, e.bg, 1'b1}) terr++;
                else if ((e.we || e.re) && mem_addr !== e.addr) terr++;
                else if (e.we && mem_wdata !== e.wd) terr++;
                if (e.we && e.bg == 2'd1 && e.elem == 3'd1 && !g1) begin obs_b1m1 = mem_wdata; g1 = 1; end
                if (e.we && e.bg == 2'd2 && e.elem == 3'd0 && !g2) begin obs_b2m0 = mem_wdata; g2 = 1; end
            end
            cnt++;
            if (cnt > 9000) begin
                chk("busy_timeout", 1, 0);
                break;
            end
        end
        last_cnt = cnt;
        chk("busy_cycles", cnt, expq.size());
        chk("trace_errors", terr, 0);
        chk("done", done, 1);
        chk("fail", fail, (fail_idx >= 0) ? 1 : 0);
        chk("fail_addr", fail_addr, ef_addr);
        chk("fail_bg", fail_bg, ef_bg);
        chk("fail_elem", fail_elem, ef_elem);
        if (hold) begin
            // start still high in DONE: a new run begins on the next edge.
            @(negedge clk);
            chk("restart_busy", busy, 1);
            chk("restart_done", done, 0);
            chk("restart_fail", fail, 0);
            start = 1'b0;
        end else begin
            acc = 0;
            repeat (4) begin
                @(negedge clk);
                acc += int'(mem_we | mem_re);
            end
            chk("post_access", acc, 0);
            chk("done_held", done, 1);
        end
    endtask

    initial begin
        int idx;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_dec_in", dec_in, 4'b0001);
        chk("rst_addr", mem_addr, 0);
        chk("rst_we_re", {mem_we, mem_re}, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_log", {fail_addr, fail_bg, fail_elem}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);

        // Fault-free run
        f_en = 1'b0;
        run_test(0);
        chk("ff_busy_len", last_cnt, FULL_BUSY);
        chk("wd_bg1_m1", obs_b1m1, 4'b1010);
        chk("wd_bg2_m0", obs_b2m0, 4'b0011);

        // Bit0 of 0x05 stuck at 0
        f_en = 1'b1; f_addr = 5; f_bit = 0; f_val = 1'b0;
        run_test(0);
        chk("s05_fail", fail, 1);
        chk("s05_addr", fail_addr, 8'h05);
        chk("s05_bg", fail_bg, 0);
        chk("s05_elem", fail_elem, 2);

        // Bit1 of 0x80 stuck at 1
        f_en = 1'b1; f_addr = 8'h80; f_bit = 1; f_val = 1'b1;
        run_test(0);
        chk("s80_addr", fail_addr, 8'h80);
        chk("s80_bg", fail_bg, 0);
        chk("s80_elem", fail_elem, 1);

        // start held for the whole run
        f_en = 1'b0;
        run_test(1);
        chk("hold_busy_len", last_cnt, FULL_BUSY);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of bg=1 M3
        idx = (2 + 10 * N) + (2 + 5 * N) + N / 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (idx) @(negedge clk);
        chk("pre_rst_dec_in", dec_in, 4'b0011);
        chk("pre_rst_access", mem_we | mem_re, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we_re", {mem_we, mem_re}, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_dec_in", dec_in, 4'b0001);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_stat", {done, fail}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_idle", busy, 0);
        run_test(0);
        chk("post_rst_len", last_cnt, FULL_BUSY);

        // Random faults (or none) with random start gaps
        repeat (3) begin
            f_en   = ($urandom_range(0, 3) != 0);
            f_addr = $urandom_range(0, N - 1);
            f_bit  = $urandom_range(0, WL - 1);
            f_val  = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_test(0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
